bellek_erisim_birimi: RTL and testbench
=======================================

# bellek_erisim_birimi

Load/store unit sitting directly upstream of the main memory, between the multi-cycle core's memory stage and the memory's word port. It accepts one RISC-V load or store per handshake, including byte and halfword types. Loads are extracted and sign- or zero-extended from the addressed word. Sub-word stores are performed as a read-modify-write, because the memory is word-only: combinational read, synchronous write, and it ignores address bits [1:0]. Misaligned and illegal accesses are rejected without touching memory.

## Interface
- ADRES_BIT, 32, address width
- VERI_BIT, 32, data width; must be 32 (byte lanes are fixed at 4)

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- istek_gecerli  in  1  core request valid
- istek_hazir  out  1  unit idle and able to accept a request
- istek_yaz  in  1  1 = store, 0 = load
- istek_tur  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- istek_adres  in  ADRES_BIT  byte address
- istek_veri  in  VERI_BIT  store data, right-aligned
- sonuc_gecerli  out  1  one-cycle completion pulse
- sonuc_veri  out  VERI_BIT  extended load result; 0 for stores and errors
- sonuc_hata  out  1  misaligned or illegal request, qualified by sonuc_gecerli
- bellek_adres  out  ADRES_BIT  word-aligned address to memory
- bellek_oku_veri  in  VERI_BIT  memory combinational read data
- bellek_yaz_veri  out  VERI_BIT  memory write data
- bellek_yaz_gecerli  out  1  memory write enable

## Operation
- **Acceptance**
  - A request is accepted on an edge where istek_gecerli && istek_hazir.
  - The unit latches istek_yaz, istek_tur, istek_adres and istek_veri; these inputs are ignored at all other times.
  - bellek_adres takes {adres[31:2], 2'b00} from the latched address.
- **States**
  - BOSTA: istek_hazir = 1.
  - OKU: captures bellek_oku_veri into the word register.
  - YAZ: bellek_yaz_gecerli = 1.
  - SONUC: sonuc_gecerli = 1, then goes to BOSTA.
- **Transitions from BOSTA on accept**
  - Error: goes to SONUC.
  - Load: goes to OKU, then SONUC.
  - Store b/h: goes to OKU, then YAZ, then SONUC.
  - Store w: goes to YAZ, then SONUC. This path applies only with the macro defined; see Configuration.
- **Errors**
  - Misaligned: h/hu with adres[0] = 1; w with adres[1:0] ≠ 0.
  - Illegal funct3: 011, 110 or 111 for any request; 100 or 101 for a store.
  - On error, sonuc_hata = 1, sonuc_veri = 0, and no memory write occurs.
- **Load extraction**
  - Byte: okunan[8*adres[1:0] +: 8].
  - Halfword: okunan[16*adres[1] +: 16].
  - b/h are sign-extended; bu/hu are zero-extended; w is passed through.
- **Store merge**
  - Only the addressed lane is replaced, with istek_veri[7:0] for b or istek_veri[15:0] for h.
  - All other lanes keep the value read in OKU.
  - w writes istek_veri whole.
- **Output hold**
  - sonuc_veri and sonuc_hata are registered and hold until the next SONUC.
  - bellek_yaz_veri and bellek_adres hold their last value.
- **Reset gating**
  - bellek_yaz_gecerli = (state == YAZ) && rst_n, so no write is issued on an edge where reset is sampled.
- **Address range**
  - Out-of-range addresses are not detected by this unit.

## Timing
- Reset values: state BOSTA, istek_hazir 1, sonuc_gecerli 0, sonuc_veri 0, sonuc_hata 0, bellek_adres 0, bellek_yaz_veri 0, bellek_yaz_gecerli 0.
- Requests present while rst_n = 0 are not accepted.
- Cycles from the accept edge to the sonuc_gecerli cycle:
  - Error: 1.
  - Load: 2.
  - Store w with macro: 2.
  - Store b/h: 3.
  - Store w without macro: 3.
- istek_hazir is low from the cycle after accept through SONUC. It returns high in the cycle after SONUC, so back-to-back requests are spaced by at least one BOSTA cycle.
- Memory write data is committed on the edge that ends the YAZ cycle; that edge is the same one that enters SONUC.
- Reset in any state returns the unit to BOSTA on that edge and discards the in-flight request with no sonuc_gecerli. If the unit is in YAZ, no memory write occurs.

## Configuration
- BELLEK_ERISIM_KELIME_KISAYOL_EN
  - Defined: word stores skip OKU and go from BOSTA straight to YAZ (2-cycle latency).
  - Undefined: all stores, including w, pass through OKU (3-cycle latency). The OKU read is discarded for w.
  - Memory contents after any sequence are identical in both builds.

## Test plan
- Memory based at 0x8000_0000:
  - sw 0xDEADBEEF at 0x8000_0010, then lw at 0x8000_0010 → sonuc_veri 0xDEADBEEF.
  - The lw's sonuc_gecerli pulse occurs 2 cycles after accept and lasts exactly 1 cycle.
- Word 0x11223344 at 0x8000_0010:
  - sb 0x5A at 0x8000_0013 → word 0x5A223344.
  - lb at 0x8000_0013 → 0x0000005A.
  - lbu at 0x8000_0010 → 0x00000044.
- sh 0x8001 at 0x8000_0012 over 0x11223344:
  - Word becomes 0x80013344.
  - lh at 0x8000_0012 → 0xFFFF8001.
  - lhu at 0x8000_0012 → 0x00008001.
- Rejected requests:
  - lw at 0x8000_0006 → sonuc_hata 1 and sonuc_veri 0, one cycle after accept.
  - sh at 0x8000_0011 → sonuc_hata 1, with bellek_yaz_gecerli never asserted and the word unchanged.
  - funct3 011 → sonuc_hata 1.
- sb in flight with rst_n driven low during YAZ:
  - No write occurs; the word keeps 0x11223344.
  - All outputs take their reset values; istek_hazir is 1 on the next cycle.
- Build-dependent timing: sw latency is 2 cycles with BELLEK_ERISIM_KELIME_KISAYOL_EN defined and 3 cycles without. Final memory contents are identical in both builds.

Source files
------------

// File: rtl/bellek_erisim_birimi.sv
// bellek_erisim_birimi: RISC-V load/store unit doing sub-word read-modify-write over a word-only memory.
// Optional macro BELLEK_ERISIM_KELIME_KISAYOL_EN lets word stores skip the read cycle.
module bellek_erisim_birimi #(
  parameter int ADRES_BIT = 32,
  parameter int VERI_BIT  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 istek_gecerli,
  output logic                 istek_hazir,
  input  logic                 istek_yaz,
  input  logic [2:0]           istek_tur,
  input  logic [ADRES_BIT-1:0] istek_adres,
  input  logic [VERI_BIT-1:0]  istek_veri,
  output logic                 sonuc_gecerli,
  output logic [VERI_BIT-1:0]  sonuc_veri,
  output logic                 sonuc_hata,
  output logic [ADRES_BIT-1:0] bellek_adres,
  input  logic [VERI_BIT-1:0]  bellek_oku_veri,
  output logic [VERI_BIT-1:0]  bellek_yaz_veri,
  output logic                 bellek_yaz_gecerli
);
  typedef enum logic [1:0] {BOSTA, OKU, YAZ, SONUC} durum_t;
  durum_t durum;
  logic yaz_r;
  logic [2:0] tur_r;
  logic [1:0] kay_r;
  logic [VERI_BIT-1:0] veri_r;
  logic hata;
  function automatic logic [VERI_BIT-1:0] cikar(input logic [VERI_BIT-1:0] w, input logic [2:0] t,
                                                input logic [1:0] a);
    logic [7:0] b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = w[16*a[1] +: 16];
    return t[1:0] == 2'b00 ? {{(VERI_BIT-8){b[7] & ~t[2]}}, b}
         : t[1:0] == 2'b01 ? {{(VERI_BIT-16){h[15] & ~t[2]}}, h} : w;
  endfunction
  function automatic logic [VERI_BIT-1:0] birlestir(input logic [VERI_BIT-1:0] w, input logic [VERI_BIT-1:0] d,
                                                    input logic [2:0] t, input logic [1:0] a);
    logic [VERI_BIT-1:0] r;
    r = w;
    if (t[1:0] == 2'b00) r[8*a +: 8] = d[7:0];
    else if (t[1:0] == 2'b01) r[16*a[1] +: 16] = d[15:0];
    else r = d;
    return r;
  endfunction
  // Illegal funct3 (including unsigned stores) or a misaligned halfword/word
  assign hata = (istek_tur == 3'b011) || (istek_tur[2:1] == 2'b11) || (istek_yaz && istek_tur[2])
             || (istek_tur[1:0] == 2'b01 && istek_adres[0])
             || (istek_tur == 3'b010 && istek_adres[1:0] != 2'b00);
  assign istek_hazir = durum == BOSTA;
  assign sonuc_gecerli = durum == SONUC;
  assign bellek_yaz_gecerli = (durum == YAZ) && rst_n;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      durum <= BOSTA;
      yaz_r <= 1'b0;
      tur_r <= 3'b000;
      kay_r <= 2'b00;
      veri_r <= '0;
      sonuc_veri <= '0;
      sonuc_hata <= 1'b0;
      bellek_adres <= '0;
      bellek_yaz_veri <= '0;
    end else begin
      case (durum)
        BOSTA: if (istek_gecerli) begin
          yaz_r <= istek_yaz;
          tur_r <= istek_tur;
          kay_r <= istek_adres[1:0];
          veri_r <= istek_veri;
          bellek_adres <= {istek_adres[ADRES_BIT-1:2], 2'b00};
          if (hata) begin
            sonuc_veri <= '0;
            sonuc_hata <= 1'b1;
            durum <= SONUC;
          end
`ifdef BELLEK_ERISIM_KELIME_KISAYOL_EN
          else if (istek_yaz && istek_tur == 3'b010) begin
            bellek_yaz_veri <= istek_veri;
            durum <= YAZ;
          end
`endif
          else durum <= OKU;
        end
        OKU: if (yaz_r) begin
          bellek_yaz_veri <= birlestir(bellek_oku_veri, veri_r, tur_r, kay_r);
          durum <= YAZ;
        end else begin
          sonuc_veri <= cikar(bellek_oku_veri, tur_r, kay_r);
          sonuc_hata <= 1'b0;
          durum <= SONUC;
        end
        YAZ: begin
          sonuc_veri <= '0;
          sonuc_hata <= 1'b0;
          durum <= SONUC;
        end
        default: durum <= BOSTA;
      endcase
    end
  end
endmodule

// File: tb/tb_bellek_erisim_birimi.sv
// tb_bellek_erisim_birimi: randomized bench for bellek_erisim_birimi against a transaction-level memory model.
module tb_bellek_erisim_birimi;
`ifdef BELLEK_ERISIM_KELIME_KISAYOL_EN
  localparam bit KISA = 1'b1;
`else
  localparam bit KISA = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic istek_gecerli = 1'b0, istek_hazir, istek_yaz = 1'b0;
  logic [2:0] istek_tur = 3'b000;
  logic [31:0] istek_adres = '0, istek_veri = '0;
  logic sonuc_gecerli, sonuc_hata, bellek_yaz_gecerli;
  logic [31:0] sonuc_veri, bellek_adres, bellek_oku_veri, bellek_yaz_veri;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic yukle = 1'b1;
  int cyc = 0, n_kars = 0, n_hata = 0;
  bit pending = 1'b0, atla = 1'b0, basla = 1'b0;
  int acc_cyc = 0, e_lat = 0, son_d = 0, d_c = 0;
  logic e_yazar = 1'b0, e_hata = 1'b0, e_son_hata = 1'b0, son_hata = 1'b0;
  logic [31:0] e_veri = '0, e_son_veri = '0, son_veri = '0, acc_adres = '0;

  bellek_erisim_birimi #(.ADRES_BIT(32), .VERI_BIT(32)) dut (
    .clk(clk), .rst_n(rst_n), .istek_gecerli(istek_gecerli), .istek_hazir(istek_hazir),
    .istek_yaz(istek_yaz), .istek_tur(istek_tur), .istek_adres(istek_adres), .istek_veri(istek_veri),
    .sonuc_gecerli(sonuc_gecerli), .sonuc_veri(sonuc_veri), .sonuc_hata(sonuc_hata),
    .bellek_adres(bellek_adres), .bellek_oku_veri(bellek_oku_veri), .bellek_yaz_veri(bellek_yaz_veri),
    .bellek_yaz_gecerli(bellek_yaz_gecerli)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ilk(input int i);
    return 32'(i) * 32'h0101_0101 ^ 32'hA5C3_5A3C;
  endfunction

  always @(posedge clk)
    if (yukle) for (int i = 0; i < 16; i++) mem[i] <= ilk(i);
    else if (bellek_yaz_gecerli) mem[bellek_adres[5:2]] <= bellek_yaz_veri;
  assign bellek_oku_veri = mem[bellek_adres[5:2]];

  task automatic chk(input string ad, input logic [31:0] g, input logic [31:0] b);
    n_kars++;
    if (g !== b) begin
      n_hata++;
      $display("FAIL %s: got %h expected %h (t=%0t)", ad, g, b, $time);
    end
  endtask

  function automatic logic [31:0] m_yukle(input logic [31:0] w, input logic [2:0] t, input logic [1:0] a);
    logic [31:0] s;
    s = w >> (8 * a);
    case (t)
      3'd0: return 32'(int'(byte'(s[7:0])));
      3'd1: return 32'(int'(shortint'(s[15:0])));
      3'd4: return s & 32'hFF;
      3'd5: return s & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_yaz(input logic [31:0] w, input logic [31:0] d, input logic [2:0] t,
                                        input logic [1:0] a);
    logic [31:0] mask;
    mask = (t == 3'd0 ? 32'hFF : t == 3'd1 ? 32'hFFFF : 32'hFFFF_FFFF) << (8 * a);
    return (w & ~mask) | ((d << (8 * a)) & mask);
  endfunction

  task automatic model_kabul(input logic y, input logic [2:0] t, input logic [31:0] adr, input logic [31:0] v);
    int n;
    bit yasal;
    n = (t[1:0] == 2'd0) ? 1 : (t[1:0] == 2'd1) ? 2 : (t[1:0] == 2'd2) ? 4 : 0;
    yasal = y ? (t <= 3'd2) : (t inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e_hata = !yasal || (n != 0 && (int'(adr[1:0]) % n) != 0);
    e_yazar = y && !e_hata;
    e_veri = (!y && !e_hata) ? m_yukle(ref_mem[adr[5:2]], t, adr[1:0]) : 32'h0;
    e_lat = e_hata ? 1 : !y ? 2 : (t == 3'd2 && KISA) ? 2 : 3;
    if (e_yazar) ref_mem[adr[5:2]] = m_yaz(ref_mem[adr[5:2]], v, t, adr[1:0]);
    acc_adres = adr;
    acc_cyc = cyc;
    pending = 1'b1;
  endtask

  task automatic islem(input logic y, input logic [2:0] t, input logic [5:0] off, input logic [31:0] v);
    @(negedge clk);
    istek_gecerli = 1'b1;
    istek_yaz = y;
    istek_tur = t;
    istek_adres = 32'h8000_0000 | 32'(off);
    istek_veri = v;
    @(posedge clk);
    #1;
    model_kabul(y, t, istek_adres, v);
    istek_gecerli = 1'b0;
    istek_yaz = 1'($urandom);
    istek_tur = 3'($urandom);
    istek_adres = $urandom;
    istek_veri = $urandom;
    while (pending) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (basla && !atla) begin
      chk("bellek_adres", bellek_adres, {acc_adres[31:2], 2'b00});
      if (pending) begin
        d_c = cyc - acc_cyc + 1;
        chk("hazir", 32'(istek_hazir), 32'(d_c > e_lat));
        chk("sonuc_gecerli", 32'(sonuc_gecerli), 32'(d_c == e_lat));
        chk("yaz_gecerli", 32'(bellek_yaz_gecerli), 32'(e_yazar && d_c == e_lat - 1));
        if (d_c == e_lat) begin
          chk("sonuc_veri", sonuc_veri, e_veri);
          chk("sonuc_hata", 32'(sonuc_hata), 32'(e_hata));
          chk("bellek_kelime", mem[acc_adres[5:2]], ref_mem[acc_adres[5:2]]);
          son_veri = sonuc_veri;
          son_hata = sonuc_hata;
          son_d = d_c;
          e_son_veri = e_veri;
          e_son_hata = e_hata;
        end else begin
          chk("tut_veri", sonuc_veri, e_son_veri);
          chk("tut_hata", 32'(sonuc_hata), 32'(e_son_hata));
        end
        if (d_c > e_lat) pending = 1'b0;
      end else begin
        chk("bos_hazir", 32'(istek_hazir), 32'd1);
        chk("bos_gecerli", 32'(sonuc_gecerli), 32'd0);
        chk("bos_yaz", 32'(bellek_yaz_gecerli), 32'd0);
        chk("bos_veri", sonuc_veri, e_son_veri);
      end
    end
  end

  task automatic sifir_kontrol(input string ad);
    chk({ad, "_hazir"}, 32'(istek_hazir), 32'd1);
    chk({ad, "_gecerli"}, 32'(sonuc_gecerli), 32'd0);
    chk({ad, "_veri"}, sonuc_veri, 32'd0);
    chk({ad, "_hata"}, 32'(sonuc_hata), 32'd0);
    chk({ad, "_adres"}, bellek_adres, 32'd0);
    chk({ad, "_yaz_veri"}, bellek_yaz_veri, 32'd0);
    chk({ad, "_yaz_gecerli"}, 32'(bellek_yaz_gecerli), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = ilk(i);
    istek_gecerli = 1'b1;
    istek_yaz = 1'b1;
    istek_tur = 3'd2;
    istek_adres = 32'h8000_0010;
    istek_veri = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    sifir_kontrol("reset");
    @(negedge clk);
    istek_gecerli = 1'b0;
    rst_n = 1'b1;
    yukle = 1'b0;
    basla = 1'b1;
    // sw then lw
    islem(1'b1, 3'd2, 6'h10, 32'hDEAD_BEEF);
    chk("sw_lat", 32'(son_d), KISA ? 32'd2 : 32'd3);
    islem(1'b0, 3'd2, 6'h10, 32'h0);
    chk("lw_veri", son_veri, 32'hDEAD_BEEF);
    chk("lw_lat", 32'(son_d), 32'd2);
    // byte lanes
    islem(1'b1, 3'd2, 6'h10, 32'h1122_3344);
    islem(1'b1, 3'd0, 6'h13, 32'hFFFF_FF5A);
    chk("sb_model", ref_mem[4], 32'h5A22_3344);
    chk("sb_mem", mem[4], 32'h5A22_3344);
    islem(1'b0, 3'd0, 6'h13, 32'h0);
    chk("lb_veri", son_veri, 32'h0000_005A);
    islem(1'b0, 3'd4, 6'h10, 32'h0);
    chk("lbu_veri", son_veri, 32'h0000_0044);
    // halfword lanes
    islem(1'b1, 3'd2, 6'h10, 32'h1122_3344);
    islem(1'b1, 3'd1, 6'h12, 32'h0000_8001);
    chk("sh_mem", mem[4], 32'h8001_3344);
    islem(1'b0, 3'd1, 6'h12, 32'h0);
    chk("lh_veri", son_veri, 32'hFFFF_8001);
    islem(1'b0, 3'd5, 6'h12, 32'h0);
    chk("lhu_veri", son_veri, 32'h0000_8001);
    // rejected requests
    islem(1'b0, 3'd2, 6'h06, 32'h0);
    chk("lw_mis_hata", 32'(son_hata), 32'd1);
    chk("lw_mis_veri", son_veri, 32'd0);
    chk("lw_mis_lat", 32'(son_d), 32'd1);
    islem(1'b1, 3'd2, 6'h10, 32'h1122_3344);
    islem(1'b1, 3'd1, 6'h11, 32'h0000_BEEF);
    chk("sh_mis_hata", 32'(son_hata), 32'd1);
    chk("sh_mis_mem", mem[4], 32'h1122_3344);
    islem(1'b0, 3'd3, 6'h10, 32'h0);
    chk("f3_011_hata", 32'(son_hata), 32'd1);
    // reset while the sb is in YAZ
    atla = 1'b1;
    @(negedge clk);
    istek_gecerli = 1'b1;
    istek_yaz = 1'b1;
    istek_tur = 3'd0;
    istek_adres = 32'h8000_0013;
    istek_veri = 32'h0000_005A;
    @(posedge clk);
    #1;
    istek_gecerli = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_yaz_once", 32'(bellek_yaz_gecerli), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_yaz_kapi", 32'(bellek_yaz_gecerli), 32'd0);
    @(posedge clk);
    #1;
    sifir_kontrol("rst_yaz");
    chk("rst_mem", mem[4], 32'h1122_3344);
    @(negedge clk);
    rst_n = 1'b1;
    e_son_veri = 32'h0;
    e_son_hata = 1'b0;
    acc_adres = 32'h0;
    @(posedge clk);
    #1;
    chk("rst_sonra_hazir", 32'(istek_hazir), 32'd1);
    atla = 1'b0;
    // randomized traffic
    for (int k = 0; k < 300; k++)
      islem(1'($urandom), 3'($urandom_range(0, 7)), 6'($urandom), $urandom);
    for (int i = 0; i < 16; i++) chk("son_mem", mem[i], ref_mem[i]);
    $display("== %0d vectors applied, %0d miscompares ==", n_kars, n_hata);
    $finish;
  end
endmodule
